// File: rtl/siu_dmu_pkt_checker.sv
// Passive checker for the SIU-to-DMU outbound link. It tracks header, gap and payload
// cycles, checks per-lane parity, flags protocol violations and keeps saturating counters.
module siu_dmu_pkt_checker #(
  parameter int DATA_W        = 128,
  parameter int PAR_W         = 8,
  parameter int PAYLOAD_BEATS = 4,
  parameter int PAYLOAD_GAP   = 1,
  parameter int ODD_PARITY    = 0,
  parameter int CNT_W         = 16
) (
  input  logic              iol2clk,
  input  logic              rst_l,
  input  logic              enable,
  input  logic              clr,
  input  logic              sio_dmu_hdr_vld,
  input  logic              sio_dmu_datareq,
  input  logic [DATA_W-1:0] sio_dmu_data,
  input  logic [PAR_W-1:0]  sio_dmu_parity,
  output logic              mon_busy,
  output logic [DATA_W-1:0] mon_hdr,
  output logic              mon_pkt_done,
  output logic              mon_err,
  output logic [PAR_W-1:0]  mon_par_err_lanes,
  output logic [CNT_W-1:0]  mon_pkt_cnt,
  output logic [CNT_W-1:0]  mon_data_pkt_cnt,
  output logic [CNT_W-1:0]  mon_par_err_cnt,
  output logic [CNT_W-1:0]  mon_proto_err_cnt
);

  localparam int             LW        = DATA_W / PAR_W;
  localparam logic           ODD_BIT   = (ODD_PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]     LAST_BEAT = 4'(PAYLOAD_BEATS - 1);
  localparam logic [1:0]     GAP_INIT  = 2'(PAYLOAD_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if ((DATA_W % PAR_W) != 0) begin : g_bad_par_w
    $error("siu_dmu_pkt_checker: DATA_W must be divisible by PAR_W");
  end
  if ((PAYLOAD_BEATS < 1) || (PAYLOAD_BEATS > 16) || (PAYLOAD_GAP < 0) || (PAYLOAD_GAP > 3)) begin : g_bad_range
    $error("siu_dmu_pkt_checker: PAYLOAD_BEATS or PAYLOAD_GAP out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GAP     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          gap_q, gap_d;
  logic [3:0]          beat_q, beat_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PAR_W-1:0]    lanes_q, lanes_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]    dpkt_cnt_q, dpkt_cnt_d;
  logic [CNT_W-1:0]    perr_cnt_q, perr_cnt_d;
  logic [CNT_W-1:0]    proto_cnt_q, proto_cnt_d;
  logic [PAR_W-1:0]    lane_err_s;
  logic                par_hit_s, proto_s, pkt_inc_s, dpkt_inc_s;

  function automatic logic [PAR_W-1:0] lane_par_err(input logic [DATA_W-1:0] data,
                                                    input logic [PAR_W-1:0]  par);
    logic [PAR_W-1:0] e;
    e = '0;
    for (int i = 0; i < PAR_W; i++) begin
      e[i] = (^data[i*LW +: LW]) ^ ODD_BIT ^ par[i];
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + CNT_ONE);
  endfunction

  assign lane_err_s = lane_par_err(sio_dmu_data, sio_dmu_parity);

  // A header in any state restarts packet tracking; a header outside IDLE is also a violation.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    beat_d      = beat_q;
    hdr_d       = hdr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    lanes_d     = lanes_q;
    par_hit_s   = 1'b0;
    proto_s     = 1'b0;
    pkt_inc_s   = 1'b0;
    dpkt_inc_s  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      par_hit_s = (sio_dmu_hdr_vld || (state_q == ST_PAYLOAD)) && (|lane_err_s);
      proto_s   = (state_q == ST_IDLE) ? (sio_dmu_datareq && !sio_dmu_hdr_vld) : sio_dmu_hdr_vld;
      if (sio_dmu_hdr_vld) begin
        hdr_d     = sio_dmu_data;
        pkt_inc_s = 1'b1;
        if (!sio_dmu_datareq) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (GAP_INIT == 2'd0) begin
          state_d = ST_PAYLOAD;
          beat_d  = 4'd0;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_INIT;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_GAP: begin
            if (gap_q <= 2'd1) begin
              state_d = ST_PAYLOAD;
              beat_d  = 4'd0;
            end else begin
              gap_d = gap_q - 2'd1;
            end
          end
          ST_PAYLOAD: begin
            if (beat_q == LAST_BEAT) begin
              done_d     = 1'b1;
              dpkt_inc_s = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              beat_d = beat_q + 4'd1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      err_d = par_hit_s || proto_s;
      if (par_hit_s) begin
        lanes_d = lanes_q | lane_err_s;
      end else begin
        lanes_d = lanes_q;
      end
    end
    if (clr) begin
      lanes_d     = '0;
      pkt_cnt_d   = '0;
      dpkt_cnt_d  = '0;
      perr_cnt_d  = '0;
      proto_cnt_d = '0;
    end else begin
      pkt_cnt_d   = pkt_inc_s  ? sat_inc(pkt_cnt_q)   : pkt_cnt_q;
      dpkt_cnt_d  = dpkt_inc_s ? sat_inc(dpkt_cnt_q)  : dpkt_cnt_q;
      perr_cnt_d  = par_hit_s  ? sat_inc(perr_cnt_q)  : perr_cnt_q;
      proto_cnt_d = proto_s    ? sat_inc(proto_cnt_q) : proto_cnt_q;
    end
  end

  // State and status registers.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      gap_q       <= 2'd0;
      beat_q      <= 4'd0;
      hdr_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lanes_q     <= '0;
      pkt_cnt_q   <= '0;
      dpkt_cnt_q  <= '0;
      perr_cnt_q  <= '0;
      proto_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      beat_q      <= beat_d;
      hdr_q       <= hdr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lanes_q     <= lanes_d;
      pkt_cnt_q   <= pkt_cnt_d;
      dpkt_cnt_q  <= dpkt_cnt_d;
      perr_cnt_q  <= perr_cnt_d;
      proto_cnt_q <= proto_cnt_d;
    end
  end

  assign mon_busy          = (state_q != ST_IDLE);
  assign mon_hdr           = hdr_q;
  assign mon_pkt_done      = done_q;
  assign mon_err           = err_q;
  assign mon_par_err_lanes = lanes_q;
  assign mon_pkt_cnt       = pkt_cnt_q;
  assign mon_data_pkt_cnt  = dpkt_cnt_q;
  assign mon_par_err_cnt   = perr_cnt_q;
  assign mon_proto_err_cnt = proto_cnt_q;

endmodule

// File: tb/tb_siu_dmu_pkt_checker.sv
// Bench for siu_dmu_pkt_checker: directed scenarios then random traffic, all checked
// against a cycle-position reference model; a second instance has 2-bit counters.
module tb_siu_dmu_pkt_checker;

  localparam int BEATS = 4;
  localparam int GAP   = 1;

  logic         clk = 1'b0;
  logic         rst_l, enable, clr, hv, dr;
  logic [127:0] data;
  logic [7:0]   par;

  logic         busy, done, err, s_busy, s_done, s_err;
  logic [127:0] hdr, s_hdr;
  logic [7:0]   lanes, s_lanes;
  logic [15:0]  pkt_cnt, dpkt_cnt, perr_cnt, proto_cnt;
  logic [1:0]   s_pkt_cnt, s_dpkt_cnt, s_perr_cnt, s_proto_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state: position within the packet counted in cycles since its header
  bit           m_active;
  int           m_k;
  logic [127:0] m_hdr;
  logic [7:0]   m_lanes;
  bit           m_done, m_err;
  int           m_pkt, m_dpkt, m_perr, m_proto;

  always #5 clk = ~clk;

  siu_dmu_pkt_checker u_dut (
    .iol2clk(clk), .rst_l(rst_l), .enable(enable), .clr(clr),
    .sio_dmu_hdr_vld(hv), .sio_dmu_datareq(dr), .sio_dmu_data(data), .sio_dmu_parity(par),
    .mon_busy(busy), .mon_hdr(hdr), .mon_pkt_done(done), .mon_err(err),
    .mon_par_err_lanes(lanes), .mon_pkt_cnt(pkt_cnt), .mon_data_pkt_cnt(dpkt_cnt),
    .mon_par_err_cnt(perr_cnt), .mon_proto_err_cnt(proto_cnt)
  );

  siu_dmu_pkt_checker #(.CNT_W(2)) u_sat (
    .iol2clk(clk), .rst_l(rst_l), .enable(enable), .clr(clr),
    .sio_dmu_hdr_vld(hv), .sio_dmu_datareq(dr), .sio_dmu_data(data), .sio_dmu_parity(par),
    .mon_busy(s_busy), .mon_hdr(s_hdr), .mon_pkt_done(s_done), .mon_err(s_err),
    .mon_par_err_lanes(s_lanes), .mon_pkt_cnt(s_pkt_cnt), .mon_data_pkt_cnt(s_dpkt_cnt),
    .mon_par_err_cnt(s_perr_cnt), .mon_proto_err_cnt(s_proto_cnt)
  );

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] good_par(input logic [127:0] d);
    logic [7:0]  p;
    logic [15:0] lane;
    for (int i = 0; i < 8; i++) begin
      lane = d[i*16 +: 16];
      p[i] = (($countones(lane) % 2) == 1);
    end
    return p;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_hdr = '0; m_lanes = '0; m_done = 0; m_err = 0;
    m_pkt = 0; m_dpkt = 0; m_perr = 0; m_proto = 0;
  endtask

  task automatic model_step();
    logic [7:0] perr;
    bit         beat, proto;
    m_done = 0;
    m_err  = 0;
    if (enable) begin
      beat  = m_active && (m_k > GAP);
      perr  = (hv || beat) ? (par ^ good_par(data)) : 8'h00;
      proto = m_active ? hv : (dr && !hv);
      m_err = proto || (perr != 8'h00);
      if (proto) m_proto++;
      if (perr != 8'h00) begin
        m_perr++;
        m_lanes |= perr;
      end
      if (hv) begin
        m_hdr = data;
        m_pkt++;
        if (dr) begin
          m_active = 1; m_k = 1;
        end else begin
          m_active = 0; m_done = 1;
        end
      end else if (m_active) begin
        if (m_k == GAP + BEATS) begin
          m_active = 0; m_done = 1; m_dpkt++;
        end else begin
          m_k++;
        end
      end
    end else begin
      m_active = 0;
    end
    if (clr) begin
      m_lanes = '0; m_pkt = 0; m_dpkt = 0; m_perr = 0; m_proto = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "/busy"},  busy,      m_active);
    check_val({tag, "/hdr"},   hdr,       m_hdr);
    check_val({tag, "/done"},  done,      m_done);
    check_val({tag, "/err"},   err,       m_err);
    check_val({tag, "/lanes"}, lanes,     m_lanes);
    check_val({tag, "/pkt"},   pkt_cnt,   sat(m_pkt, 16));
    check_val({tag, "/dpkt"},  dpkt_cnt,  sat(m_dpkt, 16));
    check_val({tag, "/perr"},  perr_cnt,  sat(m_perr, 16));
    check_val({tag, "/proto"}, proto_cnt, sat(m_proto, 16));
    check_val({tag, "/s_busy"},  s_busy,      m_active);
    check_val({tag, "/s_hdr"},   s_hdr,       m_hdr);
    check_val({tag, "/s_done"},  s_done,      m_done);
    check_val({tag, "/s_err"},   s_err,       m_err);
    check_val({tag, "/s_lanes"}, s_lanes,     m_lanes);
    check_val({tag, "/s_pkt"},   s_pkt_cnt,   sat(m_pkt, 2));
    check_val({tag, "/s_dpkt"},  s_dpkt_cnt,  sat(m_dpkt, 2));
    check_val({tag, "/s_perr"},  s_perr_cnt,  sat(m_perr, 2));
    check_val({tag, "/s_proto"}, s_proto_cnt, sat(m_proto, 2));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic drv(input string tag, input bit h, input bit d, input logic [127:0] dat,
                     input logic [7:0] flip);
    hv   = h;
    dr   = d;
    data = dat;
    par  = good_par(dat) ^ flip;
    cycle(tag);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic async_reset(input string tag);
    #2 rst_l = 1'b0;
    #1 model_reset();
    compare_all(tag);
    #2 rst_l = 1'b1;
  endtask

  int busy_n, err_n;

  initial begin
    rst_l = 1'b0; enable = 1'b1; clr = 1'b0; hv = 1'b0; dr = 1'b0; data = '0; par = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst_l = 1'b1;

    // header only, data 1
    drv("t1", 1'b1, 1'b0, 128'h1, 8'h00);
    check_val("t1_done", done, 1'b1);
    check_val("t1_pkt", pkt_cnt, 16'd1);
    check_val("t1_hdr", hdr, 128'h1);
    drv("t1_idle", 1'b0, 1'b0, rnd128(), 8'h00);
    check_val("t1_done_low", done, 1'b0);

    // data packet with a lane-3 parity error on the second beat
    busy_n = 0; err_n = 0;
    drv("t2_hdr", 1'b1, 1'b1, rnd128(), 8'h00);
    busy_n += busy; err_n += err;
    drv("t2_gap", 1'b0, 1'b0, rnd128(), 8'h00);
    busy_n += busy; err_n += err;
    for (int b = 0; b < BEATS; b++) begin
      drv("t2_beat", 1'b0, 1'b0, rnd128(), (b == 1) ? 8'h08 : 8'h00);
      busy_n += busy; err_n += err;
    end
    check_val("t2_busy_cycles", busy_n, 5);
    check_val("t2_err_pulses", err_n, 1);
    check_val("t2_done", done, 1'b1);
    check_val("t2_dpkt", dpkt_cnt, 16'd1);
    check_val("t2_perr", perr_cnt, 16'd1);
    check_val("t2_lanes", lanes, 8'h08);

    // header arriving on beat 1 abandons the first packet
    clr = 1'b1; drv("t3_clr", 1'b0, 1'b0, rnd128(), 8'h00); clr = 1'b0;
    drv("t3_hdr", 1'b1, 1'b1, rnd128(), 8'h00);
    drv("t3_gap", 1'b0, 1'b0, rnd128(), 8'h00);
    drv("t3_b0", 1'b0, 1'b0, rnd128(), 8'h00);
    drv("t3_hdr2", 1'b1, 1'b1, rnd128(), 8'h00);
    check_val("t3_proto", proto_cnt, 16'd1);
    check_val("t3_pkt", pkt_cnt, 16'd2);
    check_val("t3_dpkt0", dpkt_cnt, 16'd0);
    for (int c = 0; c < GAP + BEATS; c++) drv("t3_tail", 1'b0, 1'b0, rnd128(), 8'h00);
    check_val("t3_dpkt1", dpkt_cnt, 16'd1);

    // stray datareq in IDLE, then clr colliding with another one
    clr = 1'b1; drv("t4_clr", 1'b0, 1'b0, rnd128(), 8'h00); clr = 1'b0;
    drv("t4_stray", 1'b0, 1'b1, rnd128(), 8'h00);
    check_val("t4_proto", proto_cnt, 16'd1);
    check_val("t4_idle", busy, 1'b0);
    clr = 1'b1; drv("t4_clr_stray", 1'b0, 1'b1, rnd128(), 8'h00); clr = 1'b0;
    check_val("t4_proto_clr", proto_cnt, 16'd0);

    // 2-bit counters saturate
    for (int h = 0; h < 5; h++) drv("t5_hdr", 1'b1, 1'b0, rnd128(), 8'h00);
    check_val("t5_sat", s_pkt_cnt, 2'd3);
    check_val("t5_wide", pkt_cnt, 16'd5);

    // asynchronous reset mid-payload
    drv("t6_hdr", 1'b1, 1'b1, rnd128(), 8'h00);
    drv("t6_gap", 1'b0, 1'b0, rnd128(), 8'h00);
    drv("t6_b0", 1'b0, 1'b0, rnd128(), 8'h00);
    async_reset("t6_arst");
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_hdr0", hdr, 128'h0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      clr    = ($urandom_range(0, 49) == 0);
      drv("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), rnd128(),
          ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      if ($urandom_range(0, 499) == 0) async_reset("rnd_arst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
